// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 width/sign codes, the registered request record and fault decode.
package lsu_pkg;

    localparam int unsigned LSU_XLEN = 32;
    localparam int unsigned F3_W_BITS = 3;
    localparam int unsigned OFF_BITS = 2;
    localparam int unsigned BE_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width in bits [1:0], bit 2 selects zero-extension for loads
    localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
    localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
    localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
    localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
    localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                 we;
        logic [F3_W_BITS-1:0] funct3;
        logic [OFF_BITS-1:0]  offset;
    } lsu_req_t;

    // Illegal width code for the direction, or natural alignment violated
    function automatic logic req_fault(input logic we,
                                       input logic [F3_W_BITS-1:0] funct3,
                                       input logic [OFF_BITS-1:0] offset);
        logic f;
        f = 1'b1;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_H:    f = offset[0];
            F3_W:    f = (offset != 2'b00);
            F3_BU:   f = we;
            F3_HU:   f = we | offset[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane select + extension, store data
// replication and byte-enable generation.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [F3_W_BITS-1:0] funct3,
    input  logic [OFF_BITS-1:0]  offset,
    input  logic [LSU_XLEN-1:0]  wdata,
    input  logic [LSU_XLEN-1:0]  rdata,
    output logic [LSU_XLEN-1:0]  load_data_c,
    output logic [LSU_XLEN-1:0]  store_data_c,
    output logic [BE_BITS-1:0]   store_be_c
);

    logic [LSU_XLEN-1:0] lane;

    // Shift the addressed byte lane down to bit 0
    assign lane = rdata >> {offset, 3'b000};

    // Load extension by width and signedness
    always_comb begin
        load_data_c = '0;
        case (funct3)
            F3_B:    load_data_c = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data_c = {{16{lane[15]}}, lane[15:0]};
            F3_W:    load_data_c = lane;
            F3_BU:   load_data_c = {24'd0, lane[7:0]};
            F3_HU:   load_data_c = {16'd0, lane[15:0]};
            default: load_data_c = '0;
        endcase
    end

    // Store replication across lanes and byte enables
    always_comb begin
        store_data_c = '0;
        store_be_c   = '0;
        case (funct3)
            F3_B: begin
                store_data_c = {4{wdata[7:0]}};
                store_be_c   = 4'b0001 << offset;
            end
            F3_H: begin
                store_data_c = {2{wdata[15:0]}};
                store_be_c   = 4'b0011 << offset;
            end
            F3_W: begin
                store_data_c = wdata;
                store_be_c   = 4'b1111;
            end
            default: begin
                store_data_c = '0;
                store_be_c   = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding access, IDLE/WAIT/RESP FSM,
// registered bus and response outputs.
// Optional bus-wait timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic                 resp_fault,
    output logic                 resp_timeout,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_ack,
    input  logic [XLEN-1:0]      mem_rdata
);

    if (XLEN != 32) begin : g_xlen_check
        $error("load_store_unit supports XLEN=32 only");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("load_store_unit needs TIMEOUT_CYCLES >= 1");
    end

    state_t   state, state_d;
    lsu_req_t req_q, req_d;

    logic            req_ready_d, resp_valid_d, resp_fault_d;
    logic [XLEN-1:0] resp_data_d, mem_addr_d, mem_wdata_d;
    logic            mem_req_d, mem_we_d;
    logic [3:0]      mem_be_d;

    logic [F3_W_BITS-1:0] align_funct3;
    logic [OFF_BITS-1:0]  align_offset;
    logic [XLEN-1:0]      load_data_c, store_data_c;
    logic [3:0]           store_be_c;
    logic                 fault_c;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic             resp_timeout_d;
`else
    assign resp_timeout = 1'b0;
`endif

    // Incoming fields drive the aligner at accept, registered fields afterwards
    assign align_funct3 = (state == ST_IDLE) ? req_funct3 : req_q.funct3;
    assign align_offset = (state == ST_IDLE) ? req_addr[1:0] : req_q.offset;
    assign fault_c      = req_fault(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3       (align_funct3),
        .offset       (align_offset),
        .wdata        (req_wdata),
        .rdata        (mem_rdata),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c),
        .store_be_c   (store_be_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        req_d        = req_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_be_d     = '0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_fault_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
        wait_cnt_d     = '0;
        resp_timeout_d = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, funct3: req_funct3, offset: req_addr[1:0]};
                    if (fault_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = req_we ? store_data_c : '0;
                        mem_be_d    = req_we ? store_be_c : 4'b0000;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = req_q.we ? '0 : load_data_c;
`ifdef LSU_TIMEOUT_EN
                end else if (wait_cnt == CNT_LAST) begin
                    state_d        = ST_RESP;
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
`endif
                end else begin
                    mem_req_d   = mem_req;
                    mem_we_d    = mem_we;
                    mem_addr_d  = mem_addr;
                    mem_wdata_d = mem_wdata;
                    mem_be_d    = mem_be;
`ifdef LSU_TIMEOUT_EN
                    wait_cnt_d  = wait_cnt + CNT_W'(1);
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            state      <= state_d;
            req_q      <= req_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_fault <= resp_fault_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_be     <= mem_be_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Bus-wait counter and timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= '0;
            resp_timeout <= 1'b0;
        end else begin
            wait_cnt     <= wait_cnt_d;
            resp_timeout <= resp_timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (default build).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, resp_timeout;
    logic [31:0] resp_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_fault   (resp_fault),
        .resp_timeout (resp_timeout),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        fault;
        logic [31:0] exp_data;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [3:0]  exp_be;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, int delay,
                                logic fault, logic [31:0] exp_data,
                                logic [31:0] exp_maddr, logic [31:0] exp_mwdata,
                                logic [3:0] exp_be);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.delay = delay; v.fault = fault; v.exp_data = exp_data;
        v.exp_maddr = exp_maddr; v.exp_mwdata = exp_mwdata; v.exp_be = exp_be;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // One full transaction from a table entry
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive_req(v.we, v.f3, v.addr, v.wdata);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.fault) begin
            chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
            chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".fault"}, 32'(resp_fault), 32'd1);
            chk({tag, ".data"}, resp_data, 32'd0);
        end else begin
            chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
            chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.we));
            chk({tag, ".mem_addr"}, mem_addr, v.exp_maddr);
            chk({tag, ".mem_wdata"}, mem_wdata, v.exp_mwdata);
            chk({tag, ".mem_be"}, 32'(mem_be), 32'(v.exp_be));
            chk({tag, ".early_valid"}, 32'(resp_valid), 32'd0);
            for (int d = 0; d < v.delay; d++) begin
                @(posedge clk); #1;
                chk({tag, ".hold_req"}, 32'(mem_req), 32'd1);
                chk({tag, ".hold_addr"}, mem_addr, v.exp_maddr);
                chk({tag, ".wait_valid"}, 32'(resp_valid), 32'd0);
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".data"}, resp_data, v.exp_data);
            chk({tag, ".fault"}, 32'(resp_fault), 32'd0);
            chk({tag, ".timeout"}, 32'(resp_timeout), 32'd0);
            chk({tag, ".mem_req_drop"}, 32'(mem_req), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, ".data_zero"}, resp_data, 32'd0);
        chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int pulses;

        //           we    f3      addr          wdata         rdata         dly fault exp_data      maddr         mwdata        be
        vecs[0]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 1'b0, 32'hFFFF_FF80, 32'h0000_0100, 32'h0,        4'b0000);
        vecs[1]  = mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 0, 1'b0, 32'h0000_8001, 32'h0000_0100, 32'h0,        4'b0000);
        vecs[2]  = mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[3]  = mk(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,         32'h0000_0200, 32'hABAB_ABAB, 4'b0010);
        vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 1'b0, 32'hFFFF_8001, 32'h0000_0100, 32'h0,        4'b0000);
        vecs[5]  = mk(1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_F678, 0, 1'b0, 32'h0000_00F6, 32'h0000_0100, 32'h0,        4'b0000);
        vecs[6]  = mk(1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 1'b0, 32'h0000_007F, 32'h0000_0100, 32'h0,        4'b0000);
        vecs[7]  = mk(1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0,        4'b0000);
        vecs[8]  = mk(1'b1, 3'b001, 32'h0000_0306, 32'h1234_5678, 32'h1111_1111, 0, 1'b0, 32'h0,         32'h0000_0304, 32'h5678_5678, 4'b1100);
        vecs[9]  = mk(1'b1, 3'b010, 32'h0000_0308, 32'hCAFE_F00D, 32'h2222_2222, 1, 1'b0, 32'h0,         32'h0000_0308, 32'hCAFE_F00D, 4'b1111);
        vecs[10] = mk(1'b1, 3'b001, 32'h0000_0301, 32'h0000_1234, 32'h0,        0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[11] = mk(1'b1, 3'b010, 32'h0000_0302, 32'h0,        32'h0,         0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[12] = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[13] = mk(1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[14] = mk(1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[15] = mk(1'b0, 3'b101, 32'h0000_0103, 32'h0,        32'h0,         0, 1'b1, 32'h0,         32'h0,         32'h0,        4'b0000);
        vecs[16] = mk(1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h00A5_0000, 3, 1'b0, 32'hFFFF_FFA5, 32'h0000_0100, 32'h0,        4'b0000);

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_data", resp_data, 32'd0);
        chk("rst.fault", 32'(resp_fault), 32'd0);
        chk("rst.timeout", 32'(resp_timeout), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_be", 32'(mem_be), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Stray ack while idle produces nothing
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1 mem_ack = 1'b0;
        chk("idle_ack.valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("idle_ack.valid2", 32'(resp_valid), 32'd0);
        chk("idle_ack.ready", 32'(req_ready), 32'd1);

        // Ack delayed 5 cycles with req_valid held high
        drive_req(1'b1, 3'b000, 32'h0000_0403, 32'h0000_0011);
        @(posedge clk); #1;
        for (int d = 0; d < 5; d++) begin
            chk("hold.ready", 32'(req_ready), 32'd0);
            chk("hold.mem_req", 32'(mem_req), 32'd1);
            chk("hold.mem_addr", mem_addr, 32'h0000_0400);
            chk("hold.mem_wdata", mem_wdata, 32'h1111_1111);
            chk("hold.mem_be", 32'(mem_be), 32'(4'b1000));
            chk("hold.valid", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b1; req_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (resp_valid) pulses++;
        end
        chk("hold.pulses", 32'(pulses), 32'd1);
        chk("hold.ready_end", 32'(req_ready), 32'd1);

        // Reset in WAIT abandons the access
        drive_req(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstwait.mem_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstwait.mem_req", 32'(mem_req), 32'd0);
        chk("rstwait.ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (resp_valid) pulses++;
        end
        chk("rstwait.no_resp", 32'(pulses), 32'd0);
        run_vec(vecs[7], 100);

        // No ack for a long stretch: unit keeps waiting (default build)
        drive_req(1'b0, 3'b001, 32'h0000_0602, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
        end
        chk("stall.no_resp", 32'(pulses), 32'd0);
        chk("stall.mem_req", 32'(mem_req), 32'd1);
        chk("stall.ready", 32'(req_ready), 32'd0);
        chk("stall.timeout", 32'(resp_timeout), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h7FFF_0000;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("stall.valid", 32'(resp_valid), 32'd1);
        chk("stall.data", resp_data, 32'h0000_7FFF);
        @(posedge clk); #1;
        chk("stall.pulse_end", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, bus-wait limit used only with LSU_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core requests an access.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width/sign code.
REQ-009 req_addr  input  XLEN  byte address.
REQ-010 req_wdata  input  XLEN  store data, LSB-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_data  output  XLEN  extended load result, feeding the writeback select input.
REQ-013 resp_fault  output  1  misaligned or illegal-funct3 request, valid with resp_valid.
REQ-014 resp_timeout  output  1  bus timeout, valid with resp_valid.
REQ-015 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-016 mem_addr  output  XLEN  word address, bits [1:0] = 0.
REQ-017 mem_wdata  output  XLEN; mem_be  output  4  lane-replicated data, byte enables.
REQ-018 mem_ack  input  1; mem_rdata  input  XLEN  bus completion and read word.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-020 Accept on req_valid && req_ready; all request fields SHALL be registered at accept.
REQ-021 funct3 decode: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 SB/SH/SW (stores); any other code is a fault.
REQ-022 Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal request SHALL go IDLE->RESP, never assert mem_req, and pulse resp_fault=1 with resp_data=0.
REQ-023 Legal request SHALL go IDLE->WAIT; mem_req, mem_we, mem_addr, mem_wdata, mem_be SHALL be held stable throughout WAIT.
REQ-024 mem_ack in WAIT SHALL capture the load result and move to RESP; mem_ack outside WAIT is ignored.
REQ-025 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; minimum latency is 2 cycles from accept to resp_valid.
REQ-026 Load extract: lane = mem_rdata >> 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-027 Stores: SB replicates byte 4x, be = 0001 << addr[1:0]; SH replicates half 2x, be = 0011 << addr[1:0]; SW uses be = 1111; store resp_data = 0.
REQ-028 resp_data, resp_fault, resp_timeout SHALL be 0 whenever resp_valid = 0.

Reset
REQ-029 rst SHALL force IDLE and clear all registered state on the next edge, including mid-WAIT (mem_req deasserts the following cycle, the pending access is abandoned with no response).
REQ-030 Reset values: req_ready=1, all other outputs 0.

Configuration
REQ-031 With macro LSU_TIMEOUT_EN defined, a counter runs in WAIT; if no mem_ack arrives after TIMEOUT_CYCLES cycles, go to RESP with resp_timeout=1, resp_data=0, and drop mem_req.
REQ-032 Without LSU_TIMEOUT_EN, there is no counter, WAIT lasts indefinitely, and resp_timeout is tied 0.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum and the funct3 width/sign constants.
REQ-034 Combinational sub-module lsu_align SHALL perform lane select, extension, store replication, and byte-enable generation.

Verification
REQ-035 LB addr 0x103, rdata 0x80112233, ack next cycle -> resp_data 0xFFFFFF80 two cycles after accept.
REQ-036 LHU addr 0x102, rdata 0x8001_1234 -> resp_data 0x00008001; LW addr 0x101 -> resp_fault=1, no mem_req.
REQ-037 SB addr 0x201, wdata 0xAB -> mem_wdata 0xABABABAB, mem_be 0010, mem_addr 0x200, resp_data 0.
REQ-038 Ack delayed 5 cycles, req_valid held high -> outputs stable in WAIT, req_ready=0, a single resp_valid pulse.
REQ-039 rst asserted in WAIT -> mem_req=0 next cycle, no resp_valid; next request handled normally.
REQ-040 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> resp_timeout=1 after 4 WAIT cycles; without macro -> unit stays in WAIT.
